// File: rtl/yukle_sakla_birimi_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM states
// and small decode helpers used by both the unit and its load aligner.
package yukle_sakla_paketi;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int ZAMAN_ASIMI_VARSAYILAN = 16;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    BEKLE = 2'd1,
    YANIT = 2'd2
  } durum_e;

  // Legal means a known funct3 for the direction and a naturally aligned address.
  function automatic logic istek_yasal(input logic yaz, input logic [2:0] f3,
                                       input logic [1:0] ofs);
    logic f3_ok;
    logic hizali;
    if (yaz) f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else     f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                     (f3 == F3_BU) || (f3 == F3_HU);
    case (f3[1:0])
      2'b01:   hizali = ~ofs[0];
      2'b10:   hizali = (ofs == 2'b00);
      default: hizali = 1'b1;
    endcase
    return f3_ok && hizali;
  endfunction

  function automatic logic [3:0] bayt_en_hesapla(input logic [1:0] boyut,
                                                 input logic [1:0] ofs);
    logic [3:0] en;
    case (boyut)
      2'b00:   en = 4'b0001 << ofs;
      2'b01:   en = 4'b0011 << ofs;
      default: en = 4'b1111;
    endcase
    return en;
  endfunction

  function automatic logic [31:0] yaz_veri_cogalt(input logic [1:0] boyut,
                                                  input logic [31:0] d);
    logic [31:0] r;
    case (boyut)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/yukle_sakla_birimi_hizalayici.sv
// Load aligner: picks the addressed lane out of a memory word and applies
// sign or zero extension according to the load funct3.
module yukleme_hizalayici
  import yukle_sakla_paketi::*;
(
  input  logic [31:0] kelime_i,
  input  logic [1:0]  ofs_i,
  input  logic [2:0]  f3_i,
  output logic [31:0] sonuc_o
);

  logic [31:0] kaydirilmis;

  always_comb begin
    kaydirilmis = kelime_i >> {ofs_i, 3'b000};
    case (f3_i)
      F3_B:    sonuc_o = {{24{kaydirilmis[7]}}, kaydirilmis[7:0]};
      F3_H:    sonuc_o = {{16{kaydirilmis[15]}}, kaydirilmis[15:0]};
      F3_BU:   sonuc_o = {24'b0, kaydirilmis[7:0]};
      F3_HU:   sonuc_o = {16'b0, kaydirilmis[15:0]};
      default: sonuc_o = kaydirilmis;
    endcase
  end

endmodule

// File: rtl/yukle_sakla_birimi.sv
// RV32I load/store unit: accepts one core request, runs a byte-enabled word
// access with timeout, and reports a one-cycle completion with error flag.
module yukle_sakla_birimi
  import yukle_sakla_paketi::*;
#(
  parameter int ZAMAN_ASIMI = ZAMAN_ASIMI_VARSAYILAN,
  parameter int SAYAC_W     = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        istek_gecerli,
  input  logic        istek_yaz,
  input  logic [2:0]  istek_f3,
  input  logic [31:0] istek_adres,
  input  logic [31:0] istek_veri,
  output logic        mesgul,
  output logic        tamam,
  output logic        hata,
  output logic [31:0] sonuc,
  output logic        bellek_istek,
  output logic        bellek_yaz,
  output logic [31:0] bellek_adres,
  output logic [3:0]  bellek_bayt_en,
  output logic [31:0] bellek_yaz_veri,
  input  logic [31:0] bellek_oku_veri,
  input  logic        bellek_gecerli
);

  durum_e durum_q, durum_d;

  logic               hata_q, hata_d;
  logic [31:0]        sonuc_q, sonuc_d;
  logic               bellek_istek_q, bellek_istek_d;
  logic               bellek_yaz_q, bellek_yaz_d;
  logic [31:0]        bellek_adres_q, bellek_adres_d;
  logic [3:0]         bayt_en_q, bayt_en_d;
  logic [31:0]        yaz_veri_q, yaz_veri_d;
  logic [2:0]         f3_q, f3_d;
  logic [1:0]         ofs_q, ofs_d;
  logic [SAYAC_W-1:0] sayac_q, sayac_d;

  logic        kabul;
  logic        yasal;
  logic        sure_doldu;
  logic [31:0] hizali_sonuc;

  assign kabul      = (durum_q == BOSTA) && istek_gecerli;
  assign yasal      = istek_yasal(istek_yaz, istek_f3, istek_adres[1:0]);
  // The counter holds completed BEKLE cycles, so LIMIT-1 marks the last allowed one.
  assign sure_doldu = (sayac_q == SAYAC_W'(ZAMAN_ASIMI - 1));

  yukleme_hizalayici u_hizalayici (
    .kelime_i (bellek_oku_veri),
    .ofs_i    (ofs_q),
    .f3_i     (f3_q),
    .sonuc_o  (hizali_sonuc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) durum_q <= BOSTA;
    else      durum_q <= durum_d;
  end

  always_comb begin
    durum_d = durum_q;
    case (durum_q)
      BOSTA:   if (istek_gecerli) durum_d = yasal ? BEKLE : YANIT;
      BEKLE:   if (bellek_gecerli || sure_doldu) durum_d = YANIT;
      YANIT:   durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  always_comb begin
    mesgul = (durum_q != BOSTA);
    tamam  = (durum_q == YANIT);
  end

  always_comb begin
    hata_d         = hata_q;
    sonuc_d        = sonuc_q;
    bellek_istek_d = bellek_istek_q;
    bellek_yaz_d   = bellek_yaz_q;
    bellek_adres_d = bellek_adres_q;
    bayt_en_d      = bayt_en_q;
    yaz_veri_d     = yaz_veri_q;
    f3_d           = f3_q;
    ofs_d          = ofs_q;
    sayac_d        = sayac_q;
    if (kabul) begin
      f3_d    = istek_f3;
      ofs_d   = istek_adres[1:0];
      hata_d  = ~yasal;
      sayac_d = '0;
      // Rejected requests never touch the memory-side registers.
      if (yasal) begin
        bellek_istek_d = 1'b1;
        bellek_yaz_d   = istek_yaz;
        bellek_adres_d = {istek_adres[31:2], 2'b00};
        bayt_en_d      = bayt_en_hesapla(istek_f3[1:0], istek_adres[1:0]);
        yaz_veri_d     = yaz_veri_cogalt(istek_f3[1:0], istek_veri);
      end
    end else if (durum_q == BEKLE) begin
      sayac_d = sayac_q + SAYAC_W'(1);
      if (bellek_gecerli) begin
        bellek_istek_d = 1'b0;
        bellek_yaz_d   = 1'b0;
        hata_d         = 1'b0;
        if (!bellek_yaz_q) sonuc_d = hizali_sonuc;
      end else if (sure_doldu) begin
        bellek_istek_d = 1'b0;
        bellek_yaz_d   = 1'b0;
        hata_d         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hata_q         <= 1'b0;
      sonuc_q        <= '0;
      bellek_istek_q <= 1'b0;
      bellek_yaz_q   <= 1'b0;
      bellek_adres_q <= '0;
      bayt_en_q      <= '0;
      yaz_veri_q     <= '0;
      f3_q           <= '0;
      ofs_q          <= '0;
      sayac_q        <= '0;
    end else begin
      hata_q         <= hata_d;
      sonuc_q        <= sonuc_d;
      bellek_istek_q <= bellek_istek_d;
      bellek_yaz_q   <= bellek_yaz_d;
      bellek_adres_q <= bellek_adres_d;
      bayt_en_q      <= bayt_en_d;
      yaz_veri_q     <= yaz_veri_d;
      f3_q           <= f3_d;
      ofs_q          <= ofs_d;
      sayac_q        <= sayac_d;
    end
  end

  assign hata            = hata_q;
  assign sonuc           = sonuc_q;
  assign bellek_istek    = bellek_istek_q;
  assign bellek_yaz      = bellek_yaz_q;
  assign bellek_adres    = bellek_adres_q;
  assign bellek_bayt_en  = bayt_en_q;
  assign bellek_yaz_veri = yaz_veri_q;

endmodule

// File: tb/tb_yukle_sakla_birimi.sv
// Bench for the load/store unit: directed scenarios plus randomized accesses
// compared against an arithmetic model of size, alignment and extension rules.
module tb_yukle_sakla_birimi;

  logic        clk = 1'b0;
  logic        rst;
  logic        istek_gecerli, istek_yaz;
  logic [2:0]  istek_f3;
  logic [31:0] istek_adres, istek_veri;
  logic        mesgul, tamam, hata;
  logic [31:0] sonuc;
  logic        bellek_istek, bellek_yaz;
  logic [31:0] bellek_adres;
  logic [3:0]  bellek_bayt_en;
  logic [31:0] bellek_yaz_veri, bellek_oku_veri;
  logic        bellek_gecerli;

  int checks = 0;
  int failures = 0;
  logic [31:0] expSonuc;

  int          obsTamamAt, obsIstekCycles;
  logic        obsHata, obsMesgul, obsYaz;
  bit          obsStable;
  logic [31:0] obsSonuc, obsAdres, obsVeri;
  logic [3:0]  obsEn;

  always #5 clk = ~clk;

  yukle_sakla_birimi #(.ZAMAN_ASIMI(16), .SAYAC_W(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .istek_gecerli   (istek_gecerli),
    .istek_yaz       (istek_yaz),
    .istek_f3        (istek_f3),
    .istek_adres     (istek_adres),
    .istek_veri      (istek_veri),
    .mesgul          (mesgul),
    .tamam           (tamam),
    .hata            (hata),
    .sonuc           (sonuc),
    .bellek_istek    (bellek_istek),
    .bellek_yaz      (bellek_yaz),
    .bellek_adres    (bellek_adres),
    .bellek_bayt_en  (bellek_bayt_en),
    .bellek_yaz_veri (bellek_yaz_veri),
    .bellek_oku_veri (bellek_oku_veri),
    .bellek_gecerli  (bellek_gecerli)
  );

  // Reference model: access size in bytes, legality, lanes and extension.
  function automatic int boyutBayt(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit yasalMi(input logic yaz, input logic [2:0] f3, input logic [31:0] adr);
    bit f3ok;
    if (yaz) f3ok = (f3 <= 3'd2);
    else     f3ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return f3ok && ((int'(adr[1:0]) % boyutBayt(f3)) == 0);
  endfunction

  function automatic logic [3:0] modelEn(input logic [2:0] f3, input logic [31:0] adr);
    int n = boyutBayt(f3);
    if (n >= 4) return 4'hF;
    return 4'(((1 << n) - 1) << adr[1:0]);
  endfunction

  function automatic logic [31:0] modelYazVeri(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int n = boyutBayt(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] modelYukle(input logic [2:0] f3, input logic [1:0] ofs,
                                             input logic [31:0] kelime);
    logic [63:0] v, mask;
    int n = boyutBayt(f3);
    v = {32'b0, kelime} >> (8 * int'(ofs));
    mask = (64'd1 << (8 * n)) - 64'd1;
    v = v & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // Drives one request, plays memory with latency gecikme (0 = never answers)
  // and records what the unit did until its completion pulse.
  task automatic run_access(input logic yaz, input logic [2:0] f3, input logic [31:0] adres,
                            input logic [31:0] veri, input int gecikme,
                            input logic [31:0] kelime, input bit tut);
    bit seen = 0;
    obsTamamAt = -1; obsIstekCycles = 0; obsStable = 1;
    obsHata = 1'bx; obsSonuc = 'x; obsMesgul = 1'bx;
    obsAdres = 'x; obsEn = 'x; obsYaz = 1'bx; obsVeri = 'x;
    @(negedge clk);
    istek_gecerli = 1'b1; istek_yaz = yaz; istek_f3 = f3;
    istek_adres = adres; istek_veri = veri;
    @(negedge clk);
    istek_gecerli = tut; istek_yaz = ~yaz; istek_f3 = 3'($urandom);
    istek_adres = $urandom; istek_veri = $urandom;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (tamam) begin
        obsTamamAt = cyc; obsHata = hata; obsSonuc = sonuc; obsMesgul = mesgul;
        break;
      end
      if (bellek_istek) begin
        obsIstekCycles++;
        if (!seen) begin
          obsAdres = bellek_adres; obsEn = bellek_bayt_en;
          obsYaz = bellek_yaz; obsVeri = bellek_yaz_veri; seen = 1;
        end else if (bellek_adres !== obsAdres || bellek_bayt_en !== obsEn ||
                     bellek_yaz !== obsYaz || bellek_yaz_veri !== obsVeri) begin
          obsStable = 0;
        end
      end
      bellek_gecerli  = (gecikme > 0) && bellek_istek && (obsIstekCycles == gecikme);
      bellek_oku_veri = bellek_gecerli ? kelime : $urandom;
      @(negedge clk);
    end
    istek_gecerli = 1'b0;
    bellek_gecerli = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({mesgul, tamam, hata, bellek_istek, bellek_yaz} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected 00000",
               {mesgul, tamam, hata, bellek_istek, bellek_yaz});
    end
    checks++;
    if (sonuc !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_sonuc: got %h expected 00000000", sonuc);
    end
    checks++;
    if ({bellek_adres, bellek_bayt_en, bellek_yaz_veri} !== 68'h0) begin
      failures++;
      $display("[TB] FAIL reset_bellek: got %h/%h/%h expected zero",
               bellek_adres, bellek_bayt_en, bellek_yaz_veri);
    end
    rst = 1'b1;
  endtask

  task automatic test_lw;
    run_access(1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF, 1'b0);
    expSonuc = 32'hDEADBEEF;
    checks++;
    if (obsAdres !== 32'h100) begin
      failures++; $display("[TB] FAIL lw_adres: got %h expected 00000100", obsAdres);
    end
    checks++;
    if (obsEn !== 4'b1111) begin
      failures++; $display("[TB] FAIL lw_bayt_en: got %b expected 1111", obsEn);
    end
    checks++;
    if (obsTamamAt !== 2) begin
      failures++; $display("[TB] FAIL lw_latency: got %0d expected 2", obsTamamAt);
    end
    checks++;
    if (obsSonuc !== expSonuc || obsHata !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lw_sonuc: got %h hata=%b expected %h hata=0", obsSonuc, obsHata, expSonuc);
    end
  endtask

  task automatic test_lb_lbu;
    run_access(1'b0, 3'b000, 32'h103, 32'h0, 2, 32'h80112233, 1'b0);
    checks++;
    if (obsEn !== 4'b1000) begin
      failures++; $display("[TB] FAIL lb_bayt_en: got %b expected 1000", obsEn);
    end
    checks++;
    if (obsSonuc !== 32'hFFFFFF80) begin
      failures++; $display("[TB] FAIL lb_sign: got %h expected ffffff80", obsSonuc);
    end
    run_access(1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80112233, 1'b0);
    expSonuc = 32'h00000080;
    checks++;
    if (obsSonuc !== expSonuc) begin
      failures++; $display("[TB] FAIL lbu_zero: got %h expected %h", obsSonuc, expSonuc);
    end
  endtask

  task automatic test_sh;
    run_access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 3, 32'h55555555, 1'b0);
    checks++;
    if (obsYaz !== 1'b1 || obsEn !== 4'b1100 || obsAdres !== 32'h200) begin
      failures++;
      $display("[TB] FAIL sh_access: got yaz=%b en=%b adr=%h expected yaz=1 en=1100 adr=00000200",
               obsYaz, obsEn, obsAdres);
    end
    checks++;
    if (obsVeri !== 32'hABCDABCD) begin
      failures++; $display("[TB] FAIL sh_yaz_veri: got %h expected abcdabcd", obsVeri);
    end
    checks++;
    if (obsIstekCycles !== 3 || obsTamamAt !== 4) begin
      failures++;
      $display("[TB] FAIL sh_timing: got istek=%0d tamam=%0d expected istek=3 tamam=4",
               obsIstekCycles, obsTamamAt);
    end
    checks++;
    if (obsSonuc !== expSonuc || obsHata !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sh_sonuc_kept: got %h hata=%b expected %h hata=0", obsSonuc, obsHata, expSonuc);
    end
  endtask

  task automatic test_errors;
    logic [2:0]  f3s [2]  = '{3'b010, 3'b011};
    logic [31:0] adrs [2] = '{32'h101, 32'h0};
    for (int i = 0; i < 2; i++) begin
      run_access(1'b0, f3s[i], adrs[i], 32'h0, 1, 32'h12345678, 1'b0);
      checks++;
      if (obsIstekCycles !== 0 || obsTamamAt !== 1 || obsHata !== 1'b1) begin
        failures++;
        $display("[TB] FAIL error_%0d: got istek=%0d tamam=%0d hata=%b expected istek=0 tamam=1 hata=1",
                 i, obsIstekCycles, obsTamamAt, obsHata);
      end
      checks++;
      if (obsSonuc !== expSonuc) begin
        failures++; $display("[TB] FAIL error_%0d_sonuc: got %h expected %h", i, obsSonuc, expSonuc);
      end
    end
  endtask

  task automatic test_timeout;
    run_access(1'b0, 3'b010, 32'h300, 32'h0, 0, 32'h0, 1'b0);
    checks++;
    if (obsIstekCycles !== 16 || obsTamamAt !== 17 || obsHata !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout: got istek=%0d tamam=%0d hata=%b expected istek=16 tamam=17 hata=1",
               obsIstekCycles, obsTamamAt, obsHata);
    end
    checks++;
    if (obsSonuc !== expSonuc) begin
      failures++; $display("[TB] FAIL timeout_sonuc: got %h expected %h", obsSonuc, expSonuc);
    end
    run_access(1'b0, 3'b010, 32'h304, 32'h0, 16, 32'h13579BDF, 1'b0);
    expSonuc = 32'h13579BDF;
    checks++;
    if (obsIstekCycles !== 16 || obsTamamAt !== 17 || obsHata !== 1'b0 || obsSonuc !== expSonuc) begin
      failures++;
      $display("[TB] FAIL timeout_edge: got istek=%0d tamam=%0d hata=%b sonuc=%h expected 16/17/0/%h",
               obsIstekCycles, obsTamamAt, obsHata, obsSonuc, expSonuc);
    end
  endtask

  task automatic test_back_to_back;
    run_access(1'b0, 3'b001, 32'h46, 32'h0, 2, 32'hC0DE8001, 1'b1);
    expSonuc = 32'hFFFFC0DE;
    checks++;
    if (obsYaz !== 1'b0 || obsAdres !== 32'h44 || obsEn !== 4'b1100 || !obsStable) begin
      failures++;
      $display("[TB] FAIL busy_ignore: got yaz=%b adr=%h en=%b stable=%0d expected 0/00000044/1100/1",
               obsYaz, obsAdres, obsEn, obsStable);
    end
    checks++;
    if (obsSonuc !== expSonuc || obsMesgul !== 1'b1 || obsTamamAt !== 3) begin
      failures++;
      $display("[TB] FAIL busy_result: got %h mesgul=%b tamam=%0d expected %h mesgul=1 tamam=3",
               obsSonuc, obsMesgul, obsTamamAt, expSonuc);
    end
    run_access(1'b1, 3'b000, 32'h49, 32'hA5A5A5C3, 1, 32'h0, 1'b0);
    checks++;
    if (obsEn !== 4'b0010 || obsVeri !== 32'hC3C3C3C3 || obsTamamAt !== 2) begin
      failures++;
      $display("[TB] FAIL b2b_sb: got en=%b veri=%h tamam=%0d expected 0010/c3c3c3c3/2",
               obsEn, obsVeri, obsTamamAt);
    end
  endtask

  task automatic test_random;
    logic        yaz;
    logic [2:0]  f3;
    logic [31:0] adr, veri, kelime;
    int          gec, expTamam, expIstek;
    bit          ok;
    for (int i = 0; i < 30; i++) begin
      yaz = 1'($urandom); f3 = 3'($urandom); adr = $urandom;
      veri = $urandom; kelime = $urandom; gec = $urandom_range(1, 5);
      ok = yasalMi(yaz, f3, adr);
      run_access(yaz, f3, adr, veri, gec, kelime, 1'b0);
      if (ok && !yaz) expSonuc = modelYukle(f3, adr[1:0], kelime);
      expTamam = ok ? gec + 1 : 1;
      expIstek = ok ? gec : 0;
      checks++;
      if (obsTamamAt !== expTamam || obsIstekCycles !== expIstek || obsHata !== !ok ||
          obsSonuc !== expSonuc) begin
        failures++;
        $display("[TB] FAIL rand_%0d_done: got tamam=%0d istek=%0d hata=%b sonuc=%h expected %0d/%0d/%b/%h",
                 i, obsTamamAt, obsIstekCycles, obsHata, obsSonuc, expTamam, expIstek, !ok, expSonuc);
      end
      if (ok) begin
        checks++;
        if (obsAdres !== {adr[31:2], 2'b00} || obsEn !== modelEn(f3, adr) || obsYaz !== yaz ||
            !obsStable || (yaz && obsVeri !== modelYazVeri(f3, veri))) begin
          failures++;
          $display("[TB] FAIL rand_%0d_bus: got adr=%h en=%b yaz=%b veri=%h stable=%0d expected %h/%b/%b/%h",
                   i, obsAdres, obsEn, obsYaz, obsVeri, obsStable, {adr[31:2], 2'b00},
                   modelEn(f3, adr), yaz, modelYazVeri(f3, veri));
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int tamamSeen = 0;
    @(negedge clk);
    istek_gecerli = 1'b1; istek_yaz = 1'b0; istek_f3 = 3'b010; istek_adres = 32'h40;
    @(negedge clk);
    istek_gecerli = 1'b0;
    @(negedge clk);
    checks++;
    if (bellek_istek !== 1'b1) begin
      failures++; $display("[TB] FAIL mid_pre: got bellek_istek=%b expected 1", bellek_istek);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bellek_istek !== 1'b0 || mesgul !== 1'b0 || sonuc !== 32'h0) begin
      failures++;
      $display("[TB] FAIL mid_async: got istek=%b mesgul=%b sonuc=%h expected 0/0/00000000",
               bellek_istek, mesgul, sonuc);
    end
    expSonuc = 32'h0;
    @(negedge clk);
    rst = 1'b1; bellek_gecerli = 1'b1; bellek_oku_veri = 32'hFFFFFFFF;
    repeat (3) begin
      @(negedge clk);
      if (tamam) tamamSeen++;
    end
    bellek_gecerli = 1'b0;
    checks++;
    if (tamamSeen !== 0 || sonuc !== expSonuc) begin
      failures++;
      $display("[TB] FAIL mid_late_gecerli: got tamam_count=%0d sonuc=%h expected 0/%h",
               tamamSeen, sonuc, expSonuc);
    end
    run_access(1'b0, 3'b010, 32'h80, 32'h0, 2, 32'h0BADF00D, 1'b0);
    expSonuc = 32'h0BADF00D;
    checks++;
    if (obsTamamAt !== 3 || obsHata !== 1'b0 || obsSonuc !== expSonuc) begin
      failures++;
      $display("[TB] FAIL mid_recover: got tamam=%0d hata=%b sonuc=%h expected 3/0/%h",
               obsTamamAt, obsHata, obsSonuc, expSonuc);
    end
  endtask

  initial begin
    rst = 1'b0;
    istek_gecerli = 1'b0; istek_yaz = 1'b0; istek_f3 = 3'b0;
    istek_adres = 32'h0; istek_veri = 32'h0;
    bellek_oku_veri = 32'h0; bellek_gecerli = 1'b0;
    expSonuc = 32'h0;
    test_reset;
    test_lw;
    test_lb_lbu;
    test_sh;
    test_errors;
    test_timeout;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/yukle_sakla_birimi.md
Name: yukle_sakla_birimi

Overview:
Load/store unit between the processor core's memory-access interface and the data memory.
- Takes one RV32I load/store request at a time (funct3, byte address, store data).
- Issues a word-aligned, byte-enabled access to memory and waits for a variable-latency response.
- For loads, returns the aligned, sign- or zero-extended result to the core.
- Detects misalignment, illegal funct3 and memory timeout, and reports each as an error completion.

Parameters:
ZAMAN_ASIMI, 16, max cycles in BEKLE before a timeout error is reported (≥1)
SAYAC_W, 5, width of the timeout counter (must hold ZAMAN_ASIMI)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
istek_gecerli  input  1  core presents a request this cycle
istek_yaz  input  1  1 = store, 0 = load
istek_f3  input  3  RV32I funct3 of the load/store
istek_adres  input  32  byte address
istek_veri  input  32  store data (low byte/half/word used)
mesgul  output  1  unit is busy; requests are ignored while high
tamam  output  1  one-cycle completion pulse
hata  output  1  valid with tamam; 1 = misaligned, illegal f3 or timeout
sonuc  output  32  load result; held until the next completion
bellek_istek  output  1  memory access request, held until bellek_gecerli
bellek_yaz  output  1  1 = write access
bellek_adres  output  32  word address, {istek_adres[31:2],2'b00}
bellek_bayt_en  output  4  byte-lane enables
bellek_yaz_veri  output  32  lane-replicated store data
bellek_oku_veri  input  32  memory read word
bellek_gecerli  input  1  memory completes the access this cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - state=BOSTA.
  - mesgul, tamam, hata, bellek_istek and bellek_yaz are 0.
  - sonuc, bellek_adres, bellek_bayt_en and bellek_yaz_veri are 0.
  - Counter is 0.
  - A reset mid-access drops bellek_istek immediately; any late bellek_gecerli is ignored.
- States:
  - BOSTA→BEKLE on an accepted legal request.
  - BOSTA→YANIT on an accepted illegal request.
  - BEKLE→YANIT on bellek_gecerli or timeout.
  - YANIT→BOSTA unconditionally.
- mesgul = (state != BOSTA). A request is accepted only when istek_gecerli=1 in BOSTA. Request fields are registered on acceptance, so the core need not hold them.
- Legal funct3 values:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Any other value is illegal.
- Alignment rules:
  - Half-word accesses need adres[0]=0.
  - Word accesses need adres[1:0]=00.
  - Byte accesses are always aligned.
  - A misaligned or illegal request makes no memory access (bellek_istek stays 0).
- Byte enables, with o = adres[1:0]:
  - Byte: 0001<<o.
  - Half-word: 0011<<o.
  - Word: 1111.
- Store data is lane-replicated: sb uses {4{d[7:0]}}, sh uses {2{d[15:0]}}, sw uses d.
- Memory handshake:
  - The bellek_* outputs are registered and asserted from the cycle after acceptance.
  - They stay stable until the cycle in which bellek_gecerli=1, then deassert on the next edge.
  - bellek_gecerli outside BEKLE is ignored.
- Load result:
  - The selected lane comes from bellek_oku_veri[8*o +: 8/16/32].
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - It is registered into sonuc on bellek_gecerli.
  - Stores and error completions leave sonuc unchanged.
- Timeout:
  - The counter counts cycles in BEKLE.
  - When it reaches ZAMAN_ASIMI without bellek_gecerli, the access is aborted: bellek_istek drops and the unit goes to YANIT with hata=1.
  - If bellek_gecerli arrives in the same cycle the limit is reached, the response wins and hata=0.
- YANIT: tamam=1 for exactly one cycle, hata valid. The earliest next acceptance is the following cycle.
- Latency:
  - A legal access with memory latency L (bellek_gecerli in the L-th BEKLE cycle, L≥1) gives tamam L+1 cycles after acceptance.
  - An error completion gives tamam 1 cycle after acceptance.

Decomposition:
- Shared package yukle_sakla_paketi holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state encoding (BOSTA, BEKLE, YANIT);
  - the default ZAMAN_ASIMI.
- One combinational sub-module, yukleme_hizalayici, does lane select plus sign/zero extension (inputs: word, offset, f3; output: 32-bit result).

Test Plan:
- lw at 0x100, memory returns 0xDEADBEEF with L=1 → bellek_adres=0x100, bayt_en=1111, tamam at acceptance+2, sonuc=0xDEADBEEF, hata=0.
- lb at 0x103, memory word 0x80112233 → bayt_en=1000, sonuc=0xFFFFFF80. Same access as lbu → sonuc=0x00000080.
- sh at 0x202 with istek_veri=0x1234ABCD, L=3 → bellek_yaz=1, bayt_en=1100, yaz_veri=0xABCDABCD, bellek_istek high 3 cycles, tamam at +4, sonuc unchanged.
- lw at 0x101, then funct3=011 load → bellek_istek never asserts; each gives tamam with hata=1 one cycle after acceptance.
- No bellek_gecerli with ZAMAN_ASIMI=16 → bellek_istek drops after 16 BEKLE cycles, tamam with hata=1. Variant: bellek_gecerli on the 16th cycle → hata=0.
- rst pulled low during BEKLE → bellek_istek and mesgul go to 0 asynchronously. A later bellek_gecerli produces no tamam. A new request after reset completes normally.
